// File: rtl/membus_arbiter.sv
// membus_arbiter: shares memory port A between the CPU bus and a DMA requester.
// Every access runs grant -> drive -> wait -> ack with a fixed latency.
// CPU has strict priority. Define MEMBUS_STARVE_GUARD_EN to force DMA through
// after STARVE_MAX consecutive lost arbitrations.
module membus_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int RD_LAT     = 1,   // 1..7
    parameter int STARVE_MAX = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [7:0]        dma_wdata,
    output logic [7:0]        dma_rdata,
    output logic              dma_ack,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_data,
    output logic              mem_wren,
    input  logic [7:0]        mem_q,
    output logic [1:0]        owner
);

    localparam int CNT_W = 3;
    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             force_dma;
    logic             grant_cpu;
    logic             grant_dma;

`ifdef MEMBUS_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_cnt;

    assign force_dma = dma_req && (starve_cnt == SW'(STARVE_MAX));

    // Count CPU wins that DMA lost; clear once DMA gets in or stops asking.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (grant_dma) begin
            starve_cnt <= '0;
        end else if (state == IDLE && !dma_req) begin
            starve_cnt <= '0;
        end else if (grant_cpu && dma_req && starve_cnt != SW'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end
`else
    logic unused_starve;
    assign unused_starve = ^STARVE_MAX;
    assign force_dma     = 1'b0;
`endif

    assign grant_cpu = (state == IDLE) && cpu_req && !force_dma;
    assign grant_dma = (state == IDLE) && dma_req && (!cpu_req || force_dma);

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_cpu || grant_dma) state_nxt = ACCESS;
            ACCESS:  state_nxt = WAIT;
            WAIT:    if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch the winner at grant, pulse wren in ACCESS, return data after RD_LAT.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            mem_address <= '0;
            mem_data    <= '0;
            mem_wren    <= 1'b0;
            owner       <= OWN_NONE;
            cnt         <= '0;
            cpu_rdata   <= '0;
            cpu_ack     <= 1'b0;
            dma_rdata   <= '0;
            dma_ack     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        mem_address <= cpu_addr;
                        mem_data    <= cpu_wdata;
                        mem_wren    <= cpu_we;
                        owner       <= OWN_CPU;
                    end else if (grant_dma) begin
                        mem_address <= dma_addr;
                        mem_data    <= dma_wdata;
                        mem_wren    <= dma_we;
                        owner       <= OWN_DMA;
                    end
                end
                ACCESS: begin
                    mem_wren <= 1'b0;
                    cnt      <= CNT_W'(RD_LAT - 1);
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (owner == OWN_CPU) begin
                        cpu_rdata <= mem_q;
                        cpu_ack   <= 1'b1;
                    end else begin
                        dma_rdata <= mem_q;
                        dma_ack   <= 1'b1;
                    end
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    dma_ack <= 1'b0;
                    owner   <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed bench for membus_arbiter: one RD_LAT=1 and one RD_LAT=3 instance
// share stimulus, each with its own behavioural memory model.
// Build with MEMBUS_STARVE_GUARD_EN to exercise the DMA starvation guard.
module tb_membus_arbiter;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [17:0] cpu_addr = '0, dma_addr = '0;
    logic [7:0]  cpu_wdata = '0, dma_wdata = '0;

    logic [7:0]  c1_rdata, d1_rdata, m1_data, m1_q;
    logic        c1_ack, d1_ack, m1_wren;
    logic [17:0] m1_addr;
    logic [1:0]  own1;

    logic [7:0]  c3_rdata, d3_rdata, m3_data, m3_q;
    logic        c3_ack, d3_ack, m3_wren;
    logic [17:0] m3_addr;
    logic [1:0]  own3;

    logic        ld_en = 1'b0;
    logic [17:0] ld_addr = '0;
    logic [7:0]  ld_data = '0;

    logic [7:0]  mem1 [0:262143];
    logic [7:0]  mem3 [0:262143];
    logic [7:0]  p3 [0:2];

    int n_cmp = 0, n_err = 0;
    int wren_cnt = 0, cack_cnt = 0, dack_cnt = 0;
    logic [17:0] wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [1:0]  wr_own = '0;

    always #5 clock = ~clock;

    membus_arbiter #(.ADDR_W(18), .RD_LAT(1), .STARVE_MAX(8)) dut1 (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(c1_rdata), .cpu_ack(c1_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(d1_rdata), .dma_ack(d1_ack),
        .mem_address(m1_addr), .mem_data(m1_data), .mem_wren(m1_wren), .mem_q(m1_q),
        .owner(own1));

    membus_arbiter #(.ADDR_W(18), .RD_LAT(3), .STARVE_MAX(8)) dut3 (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(c3_rdata), .cpu_ack(c3_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(d3_rdata), .dma_ack(d3_ack),
        .mem_address(m3_addr), .mem_data(m3_data), .mem_wren(m3_wren), .mem_q(m3_q),
        .owner(own3));

    // Memory models: 1-cycle and 3-cycle read latency, plus a bench preload path.
    always @(posedge clock) begin
        if (ld_en) begin
            mem1[ld_addr] <= ld_data;
            mem3[ld_addr] <= ld_data;
        end else begin
            if (m1_wren) mem1[m1_addr] <= m1_data;
            if (m3_wren) mem3[m3_addr] <= m3_data;
        end
        m1_q  <= mem1[m1_addr];
        p3[0] <= mem3[m3_addr];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign m3_q = p3[2];

    // Monitor on the falling edge: count write strobes and acks of dut1.
    always @(negedge clock) begin
        if (m1_wren) begin
            wren_cnt++;
            wr_addr = m1_addr;
            wr_data = m1_data;
            wr_own  = own1;
        end
        if (c1_ack) cack_cnt++;
        if (d1_ack) dack_cnt++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ld(input logic [17:0] a, input logic [7:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    // One transaction on dut1; lat = ticks from raising req to seeing ack.
    task automatic xact(input bit is_dma, input bit we, input logic [17:0] a,
                        input logic [7:0] wd, output int lat, output logic [7:0] rd);
        if (is_dma) begin dma_we = we; dma_addr = a; dma_wdata = wd; dma_req = 1'b1; end
        else        begin cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1; end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!(is_dma ? d1_ack : c1_ack) && lat < 20);
        rd = is_dma ? d1_rdata : c1_rdata;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        tick();
    endtask

    initial begin
        int lat, w0, c0, n, tc, td, ncpu, ndma;
        logic [7:0] rd, rdc, rdd;
        logic [1:0] own_first;

        // Reset state
        tick(); tick();
        chk("rst_cpu_ack", c1_ack, 0);
        chk("rst_dma_ack", d1_ack, 0);
        chk("rst_cpu_rdata", c1_rdata, 0);
        chk("rst_dma_rdata", d1_rdata, 0);
        chk("rst_mem_addr", m1_addr, 0);
        chk("rst_mem_data", m1_data, 0);
        chk("rst_mem_wren", m1_wren, 0);
        chk("rst_owner", own1, 0);
        chk("rst_owner3", own3, 0);
        resetn = 1'b1;
        ld(18'h00123, 8'hA5);
        tick();

        // 1: CPU read, RD_LAT=1
        w0 = wren_cnt;
        cpu_we = 1'b0; cpu_addr = 18'h00123; cpu_req = 1'b1;
        tick();
        chk("t1_own_access", own1, 1);
        chk("t1_ack_e1", c1_ack, 0);
        tick();
        chk("t1_own_wait", own1, 1);
        chk("t1_ack_e2", c1_ack, 0);
        tick();
        chk("t1_ack_e3", c1_ack, 1);
        chk("t1_rdata", c1_rdata, 8'hA5);
        chk("t1_own_done", own1, 1);
        cpu_req = 1'b0;
        tick();
        chk("t1_ack_drop", c1_ack, 0);
        chk("t1_own_idle", own1, 0);
        chk("t1_no_wren", wren_cnt - w0, 0);

        // 2: DMA write then read back at top of memory
        w0 = wren_cnt; c0 = cack_cnt;
        xact(1'b1, 1'b1, 18'h3FFFF, 8'h3C, lat, rd);
        chk("t2_wr_lat", lat, 3);
        chk("t2_wren_once", wren_cnt - w0, 1);
        chk("t2_wr_addr", wr_addr, 18'h3FFFF);
        chk("t2_wr_data", wr_data, 8'h3C);
        chk("t2_wr_owner", wr_own, 2);
        xact(1'b1, 1'b0, 18'h3FFFF, 8'h00, lat, rd);
        chk("t2_rd_lat", lat, 3);
        chk("t2_rd_data", rd, 8'h3C);
        chk("t2_wren_total", wren_cnt - w0, 1);
        chk("t2_no_cpu_ack", cack_cnt - c0, 0);
        chk("t2_cpu_rdata_held", c1_rdata, 8'hA5);

        // 3: simultaneous requests, CPU first, DMA RD_LAT+3 later
        ld(18'h00010, 8'h11);
        ld(18'h00020, 8'h22);
        cpu_we = 1'b0; cpu_addr = 18'h00010;
        dma_we = 1'b0; dma_addr = 18'h00020;
        cpu_req = 1'b1; dma_req = 1'b1;
        n = 0; tc = 0; td = 0; rdc = '0; rdd = '0; own_first = '0;
        while (td == 0 && n < 30) begin
            tick();
            n++;
            if (n == 1) own_first = own1;
            if (c1_ack) begin tc = n; rdc = c1_rdata; cpu_req = 1'b0; end
            if (d1_ack) begin td = n; rdd = d1_rdata; dma_req = 1'b0; end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick();
        chk("t3_own_first", own_first, 1);
        chk("t3_cpu_lat", tc, 3);
        chk("t3_dma_lat", td, 7);
        chk("t3_gap", td - tc, 4);
        chk("t3_cpu_data", rdc, 8'h11);
        chk("t3_dma_data", rdd, 8'h22);

        // 4: reset during WAIT of a CPU write
        c0 = cack_cnt;
        cpu_we = 1'b1; cpu_addr = 18'h00055; cpu_wdata = 8'h77; cpu_req = 1'b1;
        tick();
        chk("t4_wren_access", m1_wren, 1);
        tick();
        resetn = 1'b0; cpu_req = 1'b0;
        tick();
        chk("t4_cpu_ack", c1_ack, 0);
        chk("t4_dma_ack", d1_ack, 0);
        chk("t4_cpu_rdata", c1_rdata, 0);
        chk("t4_dma_rdata", d1_rdata, 0);
        chk("t4_mem_addr", m1_addr, 0);
        chk("t4_mem_data", m1_data, 0);
        chk("t4_mem_wren", m1_wren, 0);
        chk("t4_owner", own1, 0);
        resetn = 1'b1;
        tick(); tick(); tick();
        chk("t4_no_ack_after", cack_cnt - c0, 0);
        chk("t4_owner_idle", own1, 0);

        // 5: DMA held while CPU re-requests continuously
        cpu_we = 1'b0; cpu_addr = 18'h00010;
        dma_we = 1'b0; dma_addr = 18'h00020; dma_req = 1'b1;
        ncpu = 0; ndma = 0;
        cpu_req = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            tick();
            if (d1_ack) begin ndma++; dma_req = 1'b0; break; end
            if (c1_ack) begin
                ncpu++;
                cpu_req = 1'b0;
                if (ncpu >= 100) break;
                tick();
                cpu_req = 1'b1;
            end
        end
        cpu_req = 1'b0; dma_req = 1'b0;
        tick(); tick(); tick(); tick(); tick();
`ifdef MEMBUS_STARVE_GUARD_EN
        chk("t5_cpu_before_dma", ncpu, 8);
        chk("t5_dma_granted", ndma, 1);
`else
        chk("t5_cpu_count", ncpu, 100);
        chk("t5_dma_starved", ndma, 0);
`endif

        // 6: RD_LAT=3, address change during WAIT is ignored
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        ld(18'h00300, 8'h5A);
        ld(18'h00301, 8'hC3);
        tick();
        cpu_we = 1'b0; cpu_addr = 18'h00300; cpu_req = 1'b1;
        n = 0;
        while (!c3_ack && n < 20) begin
            tick();
            n++;
            if (n == 2) cpu_addr = 18'h00301;
        end
        cpu_req = 1'b0;
        chk("t6_lat", n, 5);
        chk("t6_rdata", c3_rdata, 8'h5A);
        chk("t6_own", own3, 1);
        tick();
        chk("t6_ack_drop", c3_ack, 0);
        chk("t6_own_idle", own3, 0);
        tick(); tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
Name: membus_arbiter

Overview:
- Shares the single read/write port (port A) of the 256 KB general memory between two requesters: the core88 CPU bus and a DMA requester (the SD sector loader or a BIOS shadow copier).
- Sits between the CPU address decode and the memory instance.
- Sequences each access through a fixed-latency transaction: grant, drive, wait, return data with an ack pulse.
- Strict CPU priority, with an optional starvation guard for DMA.

Parameters:
ADDR_W, 18, memory address width (256 KB).
RD_LAT, 1, memory read latency in clocks from address driven to q_a valid; legal range 1..7.
STARVE_MAX, 8, number of consecutive lost arbitrations after which DMA is forced through (optional feature only).

Ports:
clock  input  1  single clock for the whole block, rising edge
resetn  input  1  reset, synchronous, active-low
cpu_req  input  1  CPU access request; held until cpu_ack
cpu_we  input  1  CPU write enable (1=write, 0=read); stable while cpu_req
cpu_addr  input  ADDR_W  CPU address; stable while cpu_req
cpu_wdata  input  8  CPU write data; stable while cpu_req
cpu_rdata  output  8  CPU read data; valid while cpu_ack
cpu_ack  output  1  one-cycle completion pulse to CPU
dma_req  input  1  DMA access request; held until dma_ack
dma_we  input  1  DMA write enable
dma_addr  input  ADDR_W  DMA address
dma_wdata  input  8  DMA write data
dma_rdata  output  8  DMA read data; valid while dma_ack
dma_ack  output  1  one-cycle completion pulse to DMA
mem_address  output  ADDR_W  to memory address_a
mem_data  output  8  to memory data_a
mem_wren  output  1  to memory wren_a
mem_q  input  8  from memory q_a
owner  output  2  current bus owner: 00 none, 01 CPU, 10 DMA

Behaviour:
- Reset (resetn=0 at a clock edge):
  - state=IDLE; all outputs 0 (both acks, both rdata, mem_address, mem_data, mem_wren, owner); wait counter 0.
  - Reset mid-transaction drops the transaction and produces no ack. mem_wren deasserts on that edge.
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - If cpu_req=1, grant CPU; else if dma_req=1, grant DMA; else stay.
  - On grant, at the same edge: register the winner's addr/wdata/we into mem_address/mem_data/mem_wren, set owner, go to ACCESS.
  - If both request in the same cycle, CPU wins; DMA stays pending.
- ACCESS: exactly one cycle. mem_wren=we of the owner for this cycle only. Next edge: mem_wren<=0, wait counter<=RD_LAT-1, go to WAIT.
- WAIT:
  - While counter!=0: decrement.
  - At the edge where counter==0: latch mem_q into the owner's rdata, assert the owner's ack, go to DONE.
  - For writes, rdata is still loaded with mem_q (don't-care to requester) and the ack timing is identical.
- DONE: ack high for exactly this cycle. Next edge: ack<=0, owner<=00, go to IDLE. Requests are not sampled in DONE.
- Requester rule: deassert req in the ack cycle, or re-request no earlier than the cycle after ack. A req still high in the cycle after ack is a new transaction.
- Latency and throughput:
  - req seen at edge E0 -> ack high in the cycle after edge E0+RD_LAT+1 (RD_LAT=1: ack after 3rd edge).
  - Back-to-back throughput: one access per RD_LAT+3 cycles.
- Outputs held between transactions:
  - mem_address and mem_data hold their last values in IDLE.
  - cpu_rdata and dma_rdata hold until their next completion.
- The non-owner's ack and rdata never change during another requester's transaction.
- Requester inputs that change during a transaction are ignored; the latched values are used.

Optional Feature:
Macro: MEMBUS_STARVE_GUARD_EN.
- Defined:
  - An internal counter (width clog2(STARVE_MAX+1)) increments at each IDLE grant to CPU while dma_req=1.
  - When the counter equals STARVE_MAX and dma_req=1, the next IDLE grant goes to DMA even if cpu_req=1.
  - The counter clears on any DMA grant, when dma_req=0 in IDLE, or on reset.
- Not defined: strict CPU priority; DMA can starve indefinitely; no counter logic.

Test Plan:
1. Reset, then CPU read addr 0x00123 with memory preloaded 0xA5, RD_LAT=1 -> mem_wren never 1; cpu_ack high exactly one cycle, after the 3rd edge following req; cpu_rdata=0xA5; owner=01 during ACCESS..DONE, then 00.
2. DMA write 0x3C to addr 0x3FFFF, then DMA read of the same address -> mem_wren high exactly one cycle with mem_address=0x3FFFF and mem_data=0x3C; the read returns dma_rdata=0x3C; cpu_ack stays 0 throughout.
3. cpu_req and dma_req rise on the same cycle (CPU read 0x00010, DMA read 0x00020) -> CPU served first; DMA granted in the IDLE cycle after cpu_ack; dma_ack arrives exactly RD_LAT+3 cycles after cpu_ack.
4. Assert resetn=0 during the WAIT of a CPU write -> no cpu_ack; state IDLE; mem_wren=0, owner=00, all outputs 0 on the next cycle.
5. With MEMBUS_STARVE_GUARD_EN, STARVE_MAX=8: CPU re-requests continuously while dma_req is held -> DMA granted after exactly 8 CPU transactions. Without the macro -> DMA is never granted over 100 CPU transactions.
6. RD_LAT=3: CPU read -> ack after edge E0+4; changing cpu_addr during WAIT does not alter the returned data.
